// File: rtl/fifo_fwft_thresh.sv
// fifo_fwft_thresh: first-word-fall-through FIFO with threshold flags.
// Capacity is 2^ADDR_WIDTH entries. That is a (DEPTH-1)-entry RAM with a
// synchronous read, plus the registered output stage. The output register
// doubles as the RAM read register, so a pop refills the head with no bubble.
// Optional macro FIFO_FWFT_STATS_EN adds push_total / pop_total counters.
module fifo_fwft_thresh #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  output logic                  underflow
`ifdef FIFO_FWFT_STATS_EN
  ,
  output logic [31:0]           push_total,
  output logic [31:0]           pop_total
`endif
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int RAM_DEPTH = DEPTH - 1;
  localparam int CW        = ADDR_WIDTH + 1;

  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_AF   = CW'(AF_THRESH);
  localparam logic [CW-1:0]         CNT_AE   = CW'(AE_THRESH);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;

  logic          push_ok;
  logic          pop_ok;
  logic          ram_empty;
  logic          load_out;
  logic          ram_rd;
  logic          bypass;
  logic          ram_wr;
  logic [CW-1:0] count_nx;

  // Pointers wrap modulo DEPTH-1, the number of RAM entries.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // Accept/route decisions. The head is always valid whenever count >= 1,
  // so the RAM is empty exactly when count <= 1.
  always_comb begin
    push_ok   = push & ~full;
    pop_ok    = pop & ~empty;
    ram_empty = (fifo_count <= CNT_ONE);
    load_out  = empty | pop_ok;
    ram_rd    = load_out & ~ram_empty;
    bypass    = load_out & ram_empty & push_ok;
    ram_wr    = push_ok & ~bypass;
    count_nx  = fifo_count;
    case ({push_ok, pop_ok})
      2'b10:   count_nx = fifo_count + CNT_ONE;
      2'b01:   count_nx = fifo_count - CNT_ONE;
      default: count_nx = fifo_count;
    endcase
  end

  // RAM write port. Writes are blocked during reset, but the contents are not cleared.
  always_ff @(posedge clk) begin
    if (!reset && ram_wr)
      mem[wr_ptr] <= data_in;
  end

  // Output register, pointers, count, flags and sticky error bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out     <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      fifo_count   <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (ram_rd) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= ptr_inc(rd_ptr);
      end else if (bypass) begin
        data_out <= data_in;
      end
      if (ram_wr)
        wr_ptr <= ptr_inc(wr_ptr);
      if (load_out)
        empty <= ~(ram_rd | bypass);
      fifo_count   <= count_nx;
      full         <= (count_nx == CNT_FULL);
      almost_full  <= (count_nx >= CNT_AF);
      almost_empty <= (count_nx <= CNT_AE);
      if (push && full)
        overflow <= 1'b1;
      if (pop && empty)
        underflow <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_STATS_EN
  // Free-running totals of accepted transfers, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      push_total <= '0;
      pop_total  <= '0;
    end else begin
      if (push_ok)
        push_total <= push_total + 32'd1;
      if (pop_ok)
        pop_total <= pop_total + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fifo_fwft_thresh.md
FIFO_FWFT_THRESH -- requirements
Module: fifo_fwft_thresh

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, entry width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8; total capacity DEPTH = 2^ADDR_WIDTH entries, counting the output register.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2; almost_full asserts when count >= AF_THRESH.
REQ-004 SHALL have parameter AE_THRESH, default 2; almost_empty asserts when count <= AE_THRESH.
REQ-005 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port push  input  1  write request.
REQ-008 SHALL have port pop  input  1  read-acknowledge of the current head.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-010 SHALL have port data_out  output  DATA_WIDTH  head entry, first-word-fall-through, registered.
REQ-011 SHALL have port empty  output  1  high when no valid head is presented.
REQ-012 SHALL have port full  output  1  high when count == DEPTH.
REQ-013 SHALL have port almost_full  output  1  threshold flag.
REQ-014 SHALL have port almost_empty  output  1  threshold flag.
REQ-015 SHALL have port fifo_count  output  ADDR_WIDTH+1  entries held, including the output register.
REQ-016 SHALL have port overflow  output  1  sticky: push seen while full.
REQ-017 SHALL have port underflow  output  1  sticky: pop seen while empty.

Function
REQ-018 Storage SHALL be a DEPTH-1 entry RAM with synchronous read, plus one output register; order strictly first-in first-out.
REQ-019 A push SHALL be accepted iff push && !full; an accepted push increments the count, with no pass-through at full even when pop is high.
REQ-020 A pop SHALL be accepted iff pop && !empty; an accepted pop decrements the count.
REQ-021 Simultaneous accepted push and pop SHALL leave fifo_count unchanged.
REQ-022 A push into an empty block SHALL bypass the RAM: data_in appears on data_out and empty falls in cycle N+1.
REQ-023 After an accepted pop, the next entry SHALL be on data_out in the following cycle with no bubble, including a back-to-back pop every cycle.
REQ-024 If count == 1 with simultaneous push and pop, data_in SHALL load directly into the output register; empty stays low.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH-1 with no lost or duplicated entry.
REQ-026 While empty == 1, data_out SHALL hold its last value.
REQ-027 fifo_count, full, almost_full and almost_empty SHALL be registered and consistent with the same cycle's state.
REQ-028 A push while full SHALL be dropped and SHALL set overflow; a pop while empty SHALL be ignored and SHALL set underflow; both stay set until reset.

Reset
REQ-029 On reset SHALL clear pointers, fifo_count=0, empty=1, full=0, almost_full=0, almost_empty=1, overflow=0, underflow=0, data_out=0.
REQ-030 Reset SHALL take priority over push/pop in the same cycle; contents in flight SHALL be discarded; RAM contents are not cleared.

Configuration
REQ-031 With macro FIFO_FWFT_STATS_EN defined, the block SHALL add 32-bit outputs push_total and pop_total counting accepted pushes/pops, wrapping at 2^32 and cleared by reset.
REQ-032 Without FIFO_FWFT_STATS_EN, these ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-033 Test: reset, then push 0x5 once -> next cycle empty=0, data_out=0x5, fifo_count=1, almost_empty=1.
REQ-034 Test: ADDR_WIDTH=3, push 8 entries 0..7 -> full=1, count=8, almost_full=1 from count 6; then a 9th push -> overflow=1, count stays 8.
REQ-035 Test: fill 8, then pop every cycle -> data_out 0,1,...,7 on consecutive cycles, then empty=1, count=0.
REQ-036 Test: simultaneous push/pop at count=1 for 20 cycles -> count stays 1, the data stream is in order, pointers wrap cleanly.
REQ-037 Test: pop while empty -> underflow=1, count=0; assert reset mid-fill (count=5) -> all flags and count return to reset values next cycle.
REQ-038 Test: with FIFO_FWFT_STATS_EN, 10 pushes and 7 pops plus 1 rejected push at full -> push_total=10, pop_total=7.
